// File: rtl/branch_flag_unit.sv
// branch_flag_unit: comparator flag register, branch condition evaluation and PC.
// Optional FLAG_CHECK_EN: flags non-one-hot flag vectors and forces such branches not-taken.
module branch_flag_unit #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmp_valid,
    input  logic            XBY,
    input  logic            YBX,
    input  logic            XEY,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [2:0]      br_cond,
    input  logic [PC_W-1:0] br_target,
    input  logic            pc_en,
    output logic [PC_W-1:0] pc,
    output logic            res_valid,
    output logic            taken,
    output logic [2:0]      flags,
    output logic            flags_valid,
    output logic            flag_err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FLAGS,
        RESOLVE
    } state_t;

    state_t          state_q;
    logic [2:0]      cond_q;
    logic [PC_W-1:0] target_q;
    logic [PC_W-1:0] pc_q;
    logic [2:0]      flags_q;
    logic [2:0]      flags_d;
    logic            fv_q;
    logic            res_valid_q;
    logic            taken_q;

    // Codes other than always/never depend on the stored flags.
    function automatic logic needs_flags(input logic [2:0] c);
        return (c != 3'b000) && (c != 3'b111);
    endfunction

    function automatic logic is_onehot(input logic [2:0] f);
        return (f == 3'b100) || (f == 3'b010) || (f == 3'b001);
    endfunction

    // Flags are {gt, lt, eq}.
    function automatic logic eval_cond(input logic [2:0] c, input logic [2:0] f);
        logic r;
        unique case (c)
            3'b000: r = 1'b1;
            3'b001: r = f[0];
            3'b010: r = !f[0];
            3'b011: r = f[2];
            3'b100: r = f[1];
            3'b101: r = f[2] | f[0];
            3'b110: r = f[1] | f[0];
            default: r = 1'b0;
        endcase
`ifdef FLAG_CHECK_EN
        if (needs_flags(c) && !is_onehot(f))
            r = 1'b0;
`endif
        return r;
    endfunction

    // Flag register contents after this edge; taken is evaluated against it
    // so a capture coinciding with accept or WAIT_FLAGS exit is honoured.
    always_comb begin
        flags_d = flags_q;
        if (cmp_valid)
            flags_d = {XBY, YBX, XEY};
    end

    // Flag capture, valid in every FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 3'b000;
            fv_q    <= 1'b0;
        end else if (cmp_valid) begin
            flags_q <= flags_d;
            fv_q    <= 1'b1;
        end
    end

`ifdef FLAG_CHECK_EN
    logic err_q;

    // Sticky error on any captured vector that is not exactly one-hot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (cmp_valid && !is_onehot(flags_d))
            err_q <= 1'b1;
    end

    assign flag_err = err_q;
`else
    assign flag_err = 1'b0;
`endif

    // Branch FSM with registered resolve outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cond_q      <= 3'b000;
            target_q    <= '0;
            res_valid_q <= 1'b0;
            taken_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    res_valid_q <= 1'b0;
                    taken_q     <= 1'b0;
                    if (br_valid) begin
                        cond_q   <= br_cond;
                        target_q <= br_target;
                        if (needs_flags(br_cond) && !fv_q && !cmp_valid) begin
                            state_q <= WAIT_FLAGS;
                        end else begin
                            state_q     <= RESOLVE;
                            res_valid_q <= 1'b1;
                            taken_q     <= eval_cond(br_cond, flags_d);
                        end
                    end
                end
                WAIT_FLAGS: begin
                    if (cmp_valid) begin
                        state_q     <= RESOLVE;
                        res_valid_q <= 1'b1;
                        taken_q     <= eval_cond(cond_q, flags_d);
                    end
                end
                RESOLVE: begin
                    state_q     <= IDLE;
                    res_valid_q <= 1'b0;
                    taken_q     <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    res_valid_q <= 1'b0;
                    taken_q     <= 1'b0;
                end
            endcase
        end
    end

    // PC: a taken branch wins over sequential increment, which wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc_q <= RESET_PC;
        else if (res_valid_q && taken_q)
            pc_q <= target_q;
        else
            pc_q <= pc_q + {{(PC_W-1){1'b0}}, pc_en};
    end

    assign br_ready    = (state_q == IDLE);
    assign pc          = pc_q;
    assign res_valid   = res_valid_q;
    assign taken       = taken_q;
    assign flags       = flags_q;
    assign flags_valid = fv_q;

endmodule

// File: tb/tb_branch_flag_unit.sv
// tb_branch_flag_unit: directed table, corner sequences and randomized
// comparison against a cycle-level reference model of branch_flag_unit.
module tb_branch_flag_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmp_valid;
    logic       xby, ybx, xey;
    logic       br_valid;
    logic       br_ready;
    logic [2:0] br_cond;
    logic [7:0] br_target;
    logic       pc_en;
    logic [7:0] pc;
    logic       res_valid;
    logic       taken;
    logic [2:0] flags;
    logic       flags_valid;
    logic       flag_err;

    int errors = 0;
    int checks = 0;

`ifdef FLAG_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    branch_flag_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .cmp_valid(cmp_valid),
        .XBY(xby), .YBX(ybx), .XEY(xey),
        .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond),
        .br_target(br_target), .pc_en(pc_en), .pc(pc),
        .res_valid(res_valid), .taken(taken), .flags(flags),
        .flags_valid(flags_valid), .flag_err(flag_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        cmp_valid = 0; xby = 0; ybx = 0; xey = 0;
        br_valid = 0; br_cond = 0; br_target = 0; pc_en = 0;
    endtask

    // Reference: plain reading of the condition-code table.
    function automatic bit ref_eval(input logic [2:0] c, input logic [2:0] f);
        bit gt, lt, eq, r;
        gt = f[2]; lt = f[1]; eq = f[0];
        case (c)
            0: r = 1;
            1: r = eq;
            2: r = !eq;
            3: r = gt;
            4: r = lt;
            5: r = gt || eq;
            6: r = lt || eq;
            default: r = 0;
        endcase
        if (CHK && c != 0 && c != 7 && $countones(f) != 1) r = 0;
        return r;
    endfunction

    typedef struct {
        logic [2:0] f;
        logic [2:0] cond;
        logic [7:0] tgt;
        bit         exp_taken;
    } vec_t;

    vec_t vt[12];

    // Model state
    int         m_phase;   // 0 idle, 1 waiting for flags, 2 resolving
    logic [7:0] m_pc;
    logic [2:0] m_flags;
    bit         m_fv, m_err;
    logic [2:0] m_cond;
    logic [7:0] m_tgt;

    task automatic model_step();
        int   ph;
        bit   fv_old, tk;
        ph     = m_phase;
        fv_old = m_fv;
        tk     = ref_eval(m_cond, m_flags);
        if (ph == 2 && tk) m_pc = m_tgt;
        else m_pc = m_pc + 8'(pc_en);
        if (cmp_valid) begin
            m_flags = {xby, ybx, xey};
            m_fv = 1;
            if (CHK && $countones(m_flags) != 1) m_err = 1;
        end
        if (ph == 2) m_phase = 0;
        else if (ph == 1 && cmp_valid) m_phase = 2;
        else if (ph == 0 && br_valid) begin
            m_cond = br_cond;
            m_tgt  = br_target;
            if (br_cond != 0 && br_cond != 7 && !fv_old && !cmp_valid) m_phase = 1;
            else m_phase = 2;
        end
    endtask

    initial begin
        logic [7:0] pc0;
        vt[0]  = '{3'b100, 3'd3, 8'h40, 1};
        vt[1]  = '{3'b100, 3'd6, 8'h41, 0};
        vt[2]  = '{3'b001, 3'd1, 8'h42, 1};
        vt[3]  = '{3'b001, 3'd2, 8'h43, 0};
        vt[4]  = '{3'b100, 3'd2, 8'h44, 1};
        vt[5]  = '{3'b010, 3'd4, 8'h45, 1};
        vt[6]  = '{3'b010, 3'd5, 8'h46, 0};
        vt[7]  = '{3'b001, 3'd5, 8'h47, 1};
        vt[8]  = '{3'b010, 3'd6, 8'h48, 1};
        vt[9]  = '{3'b001, 3'd7, 8'h49, 0};
        vt[10] = '{3'b010, 3'd0, 8'h4A, 1};
        vt[11] = '{3'b010, 3'd3, 8'h4B, 0};

        clr();
        rst_n = 0;
        #22;
        check("rst_pc", pc, 0);
        check("rst_flags", flags, 0);
        check("rst_fv", flags_valid, 0);
        check("rst_err", flag_err, 0);
        check("rst_res", res_valid, 0);
        check("rst_taken", taken, 0);
        check("rst_ready", br_ready, 1);
        rst_n = 1;
        pc_en = 1;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            check("pc_inc", pc, i);
        end
        pc_en = 0;

        // Always-branch to FE; pc_en during resolve is overridden, then wrap.
        br_valid = 1; br_cond = 0; br_target = 8'hFE;
        cyc();
        br_valid = 0;
        check("always_res", res_valid, 1);
        check("always_taken", taken, 1);
        check("always_ready", br_ready, 0);
        pc_en = 1;
        cyc();
        check("pc_FE", pc, 8'hFE);
        check("res_pulse", res_valid, 0);
        cyc();
        check("pc_FF", pc, 8'hFF);
        cyc();
        check("pc_wrap", pc, 8'h00);
        pc_en = 0;

        // Table of flag/condition combinations.
        foreach (vt[i]) begin
            cmp_valid = 1; {xby, ybx, xey} = vt[i].f;
            cyc();
            cmp_valid = 0;
            check("tbl_flags", flags, vt[i].f);
            br_valid = 1; br_cond = vt[i].cond; br_target = vt[i].tgt;
            cyc();
            br_valid = 0;
            check("tbl_res", res_valid, 1);
            check("tbl_taken", taken, vt[i].exp_taken);
            pc0 = pc;
            pc_en = 1;
            cyc();
            pc_en = 0;
            check("tbl_pc", pc, vt[i].exp_taken ? vt[i].tgt : 8'(pc0 + 1));
        end

        // EQ with no flags since reset waits for a capture.
        rst_n = 0; #2; rst_n = 1;
        check("rst2_fv", flags_valid, 0);
        br_valid = 1; br_cond = 3'd1; br_target = 8'h22;
        cyc();
        br_valid = 0;
        for (int i = 0; i < 3; i++) begin
            check("wait_ready", br_ready, 0);
            check("wait_res", res_valid, 0);
            cyc();
        end
        cmp_valid = 1; xey = 1;
        cyc();
        clr();
        check("wait_exit_res", res_valid, 1);
        check("wait_exit_taken", taken, 1);
        cyc();
        check("wait_pc", pc, 8'h22);
        check("wait_ready2", br_ready, 1);

        // Capture in the accept cycle is used; taken overrides pc_en.
        br_valid = 1; br_cond = 3'd4; br_target = 8'h5A;
        cmp_valid = 1; ybx = 1;
        cyc();
        clr();
        check("lt_sim_taken", taken, 1);
        pc_en = 1;
        cyc();
        pc_en = 0;
        check("lt_sim_pc", pc, 8'h5A);

        // Capture during resolve affects only later branches.
        br_valid = 1; br_cond = 3'd3; br_target = 8'h66;
        cyc();
        clr();
        check("gt_old_taken", taken, 0);
        cmp_valid = 1; xby = 1;
        cyc();
        clr();
        check("late_flags", flags, 3'b100);
        check("late_pc", pc, 8'h5A);

        // Non-one-hot vector.
        cmp_valid = 1; {xby, ybx, xey} = 3'b110;
        cyc();
        clr();
        check("bad_err", flag_err, CHK);
        br_valid = 1; br_cond = 3'd5; br_target = 8'h11;
        cyc();
        br_valid = 0;
        check("bad_ge_taken", taken, !CHK);
        cyc();
        br_valid = 1; br_cond = 3'd0; br_target = 8'h33;
        cyc();
        br_valid = 0;
        check("bad_always_taken", taken, 1);
        cyc();
        check("bad_always_pc", pc, 8'h33);
        check("err_sticky", flag_err, CHK);

        // Reset in the middle of resolve.
        br_valid = 1; br_cond = 3'd0; br_target = 8'h77;
        cyc();
        br_valid = 0;
        check("mid_res", res_valid, 1);
        #2 rst_n = 0;
        #1;
        check("mid_rst_res", res_valid, 0);
        check("mid_rst_pc", pc, 0);
        check("mid_rst_fv", flags_valid, 0);
        check("mid_rst_ready", br_ready, 1);
        check("mid_rst_err", flag_err, 0);
        rst_n = 1;
        cyc();
        check("mid_rst_discard", pc, 0);

        // Randomized run against the model.
        m_phase = 0; m_pc = 0; m_flags = 0; m_fv = 0; m_err = 0;
        m_cond = 0; m_tgt = 0;
        for (int n = 0; n < 3000; n++) begin
            cmp_valid = ($urandom_range(0, 9) < 3);
            {xby, ybx, xey} = ($urandom_range(0, 7) == 0) ?
                3'($urandom) : 3'(1 << $urandom_range(0, 2));
            br_valid  = $urandom_range(0, 1);
            br_cond   = 3'($urandom);
            br_target = 8'($urandom);
            pc_en     = $urandom_range(0, 1);
            model_step();
            cyc();
            check("rnd",
                  {pc, flags, flags_valid, flag_err, res_valid, taken, br_ready},
                  {m_pc, m_flags, m_fv, m_err, m_phase == 2,
                   (m_phase == 2) && ref_eval(m_cond, m_flags), m_phase == 0});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
